// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM state encoding and
// synchronizer depth.
package i2s_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StLeft  = 2'd1,
        StRight = 2'd2
    } i2s_state_e;

    // Index width that stays legal for a one-bit word.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, plus a rising-edge
// pulse derived from the synchronized level.
module i2s_edge_sync
    import i2s_pkg::*;
#(
    parameter int unsigned DEPTH = SYNC_DEPTH
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], async_in};
            prev_q <= sync_q[DEPTH-1];
        end
    end

    assign sync_out = sync_q[DEPTH-1];
    assign rise_out = sync_q[DEPTH-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrck/sdata on clk_in, deserializes left/right
// words and presents them as a valid/ready pair. Define I2S_RX_OVR_EN for ovr_out.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned PDATA_WIDTH = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   lrck_in,
    input  logic                   sclk_in,
    input  logic                   sdata_in,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   pvalid_out,
    input  logic                   pready_in
`ifdef I2S_RX_OVR_EN
    ,
    output logic                   ovr_out
`endif
);

    localparam int unsigned CNT_W = $clog2(PDATA_WIDTH + 1);
    localparam int unsigned IDX_W = idx_width(PDATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PDATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchronized inputs
    logic sclk_rise;
    logic lrck_sync;
    logic sdata_sync;
    logic unused_sclk_lvl;
    logic unused_lrck_rise;
    logic unused_sdata_rise;

    i2s_edge_sync #(.DEPTH(SYNC_DEPTH)) u_sclk_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (sclk_in),
        .sync_out (unused_sclk_lvl),
        .rise_out (sclk_rise)
    );

    i2s_edge_sync #(.DEPTH(SYNC_DEPTH)) u_lrck_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (lrck_in),
        .sync_out (lrck_sync),
        .rise_out (unused_lrck_rise)
    );

    i2s_edge_sync #(.DEPTH(SYNC_DEPTH)) u_sdata_sync (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .async_in (sdata_in),
        .sync_out (sdata_sync),
        .rise_out (unused_sdata_rise)
    );

    // Sample stage: one registered bit/lrck pair per detected sclk rise
    logic smp_valid_q;
    logic smp_lrck_q;
    logic smp_data_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            smp_valid_q <= 1'b0;
            smp_lrck_q  <= 1'b0;
            smp_data_q  <= 1'b0;
        end else begin
            smp_valid_q <= sclk_rise;
            smp_lrck_q  <= lrck_sync;
            smp_data_q  <= sdata_sync;
        end
    end

    // Deserializer and frame FSM
    i2s_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PDATA_WIDTH-1:0] shift_q, shift_d;
    logic                   prev_lrck_q, prev_lrck_d;
    logic [PDATA_WIDTH-1:0] left_q, left_d;
    logic                   pub_q, pub_d;
    logic [PDATA_WIDTH-1:0] pub_left_q, pub_left_d;
    logic [PDATA_WIDTH-1:0] pub_right_q, pub_right_d;
    logic [PDATA_WIDTH-1:0] word_cur;
    logic [IDX_W-1:0]       bit_idx;
    logic                   boundary;

    assign bit_idx  = IDX_W'(CNT_MAX - CNT_ONE - cnt_q);
    assign boundary = smp_valid_q & (smp_lrck_q != prev_lrck_q);

    // Current word with this sample merged in; bits past the word width are dropped.
    always_comb begin
        word_cur = shift_q;
        if (cnt_q < CNT_MAX) begin
            word_cur[bit_idx] = smp_data_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StSync;
            cnt_q       <= '0;
            shift_q     <= '0;
            prev_lrck_q <= 1'b0;
            left_q      <= '0;
            pub_q       <= 1'b0;
            pub_left_q  <= '0;
            pub_right_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            prev_lrck_q <= prev_lrck_d;
            left_q      <= left_d;
            pub_q       <= pub_d;
            pub_left_q  <= pub_left_d;
            pub_right_q <= pub_right_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        prev_lrck_d = prev_lrck_q;
        left_d      = left_q;
        pub_d       = 1'b0;
        pub_left_d  = pub_left_q;
        pub_right_d = pub_right_q;

        if (smp_valid_q) begin
            prev_lrck_d = smp_lrck_q;
            if (boundary) begin
                // Boundary bit is the LSB of the word that just ended.
                cnt_d   = '0;
                shift_d = '0;
                unique case (state_q)
                    StSync: begin
                        if (!smp_lrck_q) begin
                            state_d = StLeft;
                        end
                    end
                    StLeft: begin
                        if (smp_lrck_q) begin
                            left_d  = word_cur;
                            state_d = StRight;
                        end
                    end
                    StRight: begin
                        if (!smp_lrck_q) begin
                            pub_d       = 1'b1;
                            pub_left_d  = left_q;
                            pub_right_d = word_cur;
                            state_d     = StLeft;
                        end
                    end
                    default: state_d = StSync;
                endcase
            end else begin
                shift_d = word_cur;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    // Output holding register with valid/ready handshake
    logic                   pvalid_q;
    logic [PDATA_WIDTH-1:0] pldata_q;
    logic [PDATA_WIDTH-1:0] prdata_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pvalid_q <= 1'b0;
            pldata_q <= '0;
            prdata_q <= '0;
        end else if (pub_q) begin
            // A new pair always wins, even over an unconsumed one.
            pvalid_q <= 1'b1;
            pldata_q <= pub_left_q;
            prdata_q <= pub_right_q;
        end else if (pvalid_q && pready_in) begin
            pvalid_q <= 1'b0;
        end
    end

    assign pvalid_out = pvalid_q;
    assign pldata_out = pldata_q;
    assign prdata_out = prdata_q;

`ifdef I2S_RX_OVR_EN
    logic ovr_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovr_q <= 1'b0;
        end else if (pub_q && pvalid_q && !pready_in) begin
            ovr_q <= 1'b1;
        end
    end

    assign ovr_out = ovr_q;
`endif

endmodule
